sram_access_sched: RTL and testbench
====================================

// Module: sram_access_sched
// PURPOSE
//  AHB-side access scheduler for the SRAM subsystem memory groups. Converts qualified
//  AHB transfers into per-group synchronous-SRAM strobes.
//  - Reads are issued in the address phase.
//  - Writes are issued in the data phase, because hwdata is only valid then.
//  - Raises rw_conflict when a read address phase hits the same group as an in-flight
//    write; the read is then deferred one cycle. Sits between the AHB slave port and
//    the SRAM group macros, and drives RWconflict of the response generator.
// PARAMETERS
//  NUM_GROUPS  4   number of SRAM groups (power of 2, >=2); GW = log2(NUM_GROUPS)
//  MEM_AW      10  word-address width of each group macro
//  GRP_LSB     12  lowest haddr bit of the group field, haddr[GRP_LSB +: GW]; must be >= MEM_AW+2
// PORTS
//  hclk          in   1              AHB clock
//  n_hreset      in   1              AHB reset, asynchronous, active-low
//  haddr         in   32             AHB address (address phase)
//  hwrite        in   1              1=write, 0=read (address phase)
//  hsize         in   3              transfer size; only 000/001/010 reach here qualified
//  valid_access  in   1              qualified address phase (hsel & htrans[1] & hready_in & ~size_error)
//  hwdata        in   32             AHB write data (data phase)
//  rw_conflict   out  1              read/write same-group collision this cycle (combinational)
//  mem_cs        out  NUM_GROUPS     per-group chip select
//  mem_we        out  NUM_GROUPS     per-group write enable (valid with mem_cs)
//  mem_addr      out  NUM_GROUPS*MEM_AW  per-group word address, group g at [g*MEM_AW +: MEM_AW]
//  mem_bwe       out  NUM_GROUPS*4   per-group byte write enables, little-endian
//  mem_wdata     out  32             write data, shared by all groups (= hwdata)
//  rd_grp        out  GW             group whose read data the read mux selects (registered)
// BEHAVIOUR
//  - Decode: grp = haddr[GRP_LSB +: GW]; waddr = haddr[2 +: MEM_AW].
//  - Byte enables from hsize/haddr[1:0]:
//    - byte: 4'b0001 << addr[1:0]
//    - half: addr[1] ? 4'b1100 : 4'b0011
//    - word: 4'b1111
//  - FSM states: S_IDLE, S_WR (write data phase pending), S_RDDEF (deferred read pending).
//  - Write address phase (valid_access & hwrite):
//    - Capture wr_grp/wr_addr/wr_bwe in a register.
//    - Next state S_WR.
//  - S_WR (write data phase):
//    - Drive mem_cs[wr_grp]=1, mem_we[wr_grp]=1, captured addr and bwe; mem_wdata=hwdata.
//    - Concurrent read address phase (valid_access & ~hwrite):
//      - Different group: issue the read in the same cycle too (mem_cs[grp]=1, mem_we=0). Next S_IDLE.
//      - Same group: rw_conflict=1 and no read strobe. Capture rd grp/addr. Next S_RDDEF.
//    - Concurrent write address phase: next S_WR with the new capture (back-to-back writes).
//    - No access: next S_IDLE.
//  - S_IDLE:
//    - Read address phase: issue the read immediately (cs=1, we=0). Stay in S_IDLE.
//    - Write address phase: go to S_WR.
//  - S_RDDEF:
//    - The response generator holds hready low this cycle.
//    - Issue the deferred read (cs=1, we=0, captured addr). Next S_IDLE.
//    - valid_access asserted in S_RDDEF is a protocol violation: ignore the transfer (no strobe, no capture).
//  - rw_conflict asserts only in S_WR with a same-group read address phase. It is never asserted in S_IDLE or S_RDDEF.
//  - rd_grp:
//    - Loaded with the read's group on the clock edge ending the cycle that issues the read strobe.
//    - Holds otherwise, so it is valid in the cycle the SRAM returns data.
//  - Read-after-write to the same address in the same group always returns the new data; the conflict deferral guarantees ordering.
//  - At most one write and one read strobe per cycle, never both to the same group.
//  - Unselected groups: cs=0, we=0, addr/bwe=0.
//  - Reset (asynchronous, any state, including mid-write):
//    - State -> S_IDLE.
//    - All mem_cs/mem_we/mem_bwe/mem_addr=0, rw_conflict=0, rd_grp=0.
//    - Any pending write or deferred read is dropped.
//  - Latency:
//    - Read: strobe in the address-phase cycle (+1 cycle if deferred); data the following cycle.
//    - Write: strobe exactly 1 cycle after the address phase.
// TESTING
//  1. Word write haddr=0x104, hwdata=0xDEADBEEF -> next cycle:
//     mem_cs=0001, mem_we=0001, group0 addr=0x041, bwe=1111, mem_wdata=0xDEADBEEF.
//  2. Byte write haddr=0x2006 -> next cycle: group2 cs/we=1, addr=0x001, bwe=0100.
//     Half write haddr=0x2006 -> bwe=1100.
//  3. Write 0x104, then read 0x108 in its data phase -> rw_conflict=1 in that cycle, only the write strobed.
//     Next cycle: group0 cs=1, we=0, addr=0x042; rd_grp=0 afterwards.
//  4. Write 0x104, then read 0x1008 -> rw_conflict=0; same cycle has group0 write and group1 read (cs=0011, we=0001); rd_grp=1.
//  5. Back-to-back writes 0x0, 0x1000, 0x0 -> write strobes on groups 0,1,0 on three consecutive cycles, no conflict.
//  6. n_hreset low during S_WR and during S_RDDEF -> all outputs 0 immediately.
//     After release the dropped write/read is never issued; the next read at 0x0 strobes normally.

Source files
------------

// File: rtl/sram_access_sched_if.sv
// AHB-side transfer signals and per-group SRAM strobes of the access scheduler.
// The master modport is the AHB slave port and read mux side; the slave modport is the scheduler.
interface sram_access_sched_if #(
   parameter int NUM_GROUPS = 4,
   parameter int MEM_AW     = 10
);
   localparam int GW = $clog2(NUM_GROUPS);

   logic [31:0]                  haddr;
   logic                         hwrite;
   logic [2:0]                   hsize;
   logic                         valid_access;
   logic [31:0]                  hwdata;
   logic                         rw_conflict;
   logic [NUM_GROUPS-1:0]        mem_cs;
   logic [NUM_GROUPS-1:0]        mem_we;
   logic [NUM_GROUPS*MEM_AW-1:0] mem_addr;
   logic [NUM_GROUPS*4-1:0]      mem_bwe;
   logic [31:0]                  mem_wdata;
   logic [GW-1:0]                rd_grp;

   modport master (
      output haddr, hwrite, hsize, valid_access, hwdata,
      input  rw_conflict, mem_cs, mem_we, mem_addr, mem_bwe, mem_wdata, rd_grp
   );

   modport slave (
      input  haddr, hwrite, hsize, valid_access, hwdata,
      output rw_conflict, mem_cs, mem_we, mem_addr, mem_bwe, mem_wdata, rd_grp
   );
endinterface

// File: rtl/sram_access_sched.sv
// Turns qualified AHB transfers into per-group SRAM strobes: reads in the address phase,
// writes one cycle later with hwdata; a same-group read during a write data phase is deferred a cycle.
module sram_access_sched #(
   parameter int NUM_GROUPS = 4,
   parameter int MEM_AW     = 10,
   parameter int GRP_LSB    = 12
) (
   input logic              hclk,
   input logic              n_hreset,
   sram_access_sched_if.slave bus
);
   localparam int GW = $clog2(NUM_GROUPS);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RDDEF} state_t;

   typedef struct packed {
      logic [GW-1:0]     grp;
      logic [MEM_AW-1:0] addr;
      logic [3:0]        bwe;
   } wr_cap_t;

   typedef struct packed {
      logic [GW-1:0]     grp;
      logic [MEM_AW-1:0] addr;
   } rd_cap_t;

   state_t  state;
   wr_cap_t wr_q;
   rd_cap_t def_q;
   logic [GW-1:0] rd_grp_q;

   logic [GW-1:0]     grp;
   logic [MEM_AW-1:0] waddr;
   logic [3:0]        bwe;
   logic              acc;
   logic              rd_req;
   logic              wr_req;
   logic              wr_act;
   logic              conflict;
   logic              rd_now;
   logic              rd_act;
   logic [GW-1:0]     rd_sel_grp;
   logic [MEM_AW-1:0] rd_sel_addr;

   logic [NUM_GROUPS-1:0]        cs;
   logic [NUM_GROUPS-1:0]        we;
   logic [NUM_GROUPS*MEM_AW-1:0] addr;
   logic [NUM_GROUPS*4-1:0]      bwe_all;

   // Only the decoded fields of haddr and the low hsize codes matter here.
   logic unused_ok;
   assign unused_ok = ^{bus.haddr, bus.hsize};

   assign grp   = bus.haddr[GRP_LSB +: GW];
   assign waddr = bus.haddr[2 +: MEM_AW];

   always_comb begin
      bwe = 4'b1111;
      case (bus.hsize)
         3'b000:  bwe = 4'b0001 << bus.haddr[1:0];
         3'b001:  bwe = bus.haddr[1] ? 4'b1100 : 4'b0011;
         default: bwe = 4'b1111;
      endcase
   end

   // Transfers are masked during reset so strobes drop the moment n_hreset falls.
   assign acc      = bus.valid_access & n_hreset & (state != S_RDDEF);
   assign rd_req   = acc & ~bus.hwrite;
   assign wr_req   = acc & bus.hwrite;
   assign wr_act   = (state == S_WR);
   assign conflict = wr_act & rd_req & (grp == wr_q.grp);
   assign rd_now   = rd_req & ~conflict;
   assign rd_act   = rd_now | (state == S_RDDEF);

   assign rd_sel_grp  = (state == S_RDDEF) ? def_q.grp  : grp;
   assign rd_sel_addr = (state == S_RDDEF) ? def_q.addr : waddr;

   always_comb begin
      cs      = '0;
      we      = '0;
      addr    = '0;
      bwe_all = '0;
      for (int g = 0; g < NUM_GROUPS; g++) begin
         if (wr_act && wr_q.grp == GW'(g)) begin
            cs[g]                    = 1'b1;
            we[g]                    = 1'b1;
            addr[g*MEM_AW +: MEM_AW] = wr_q.addr;
            bwe_all[g*4 +: 4]        = wr_q.bwe;
         end else if (rd_act && rd_sel_grp == GW'(g)) begin
            cs[g]                    = 1'b1;
            addr[g*MEM_AW +: MEM_AW] = rd_sel_addr;
         end
      end
   end

   always_ff @(posedge hclk or negedge n_hreset) begin
      if (!n_hreset) begin
         state    <= S_IDLE;
         wr_q     <= '0;
         def_q    <= '0;
         rd_grp_q <= '0;
      end else begin
         if (wr_req) begin
            wr_q <= '{grp: grp, addr: waddr, bwe: bwe};
         end
         if (conflict) begin
            def_q <= '{grp: grp, addr: waddr};
         end
         if (rd_act) begin
            rd_grp_q <= rd_sel_grp;
         end
         case (state)
            S_IDLE:  state <= wr_req ? S_WR : S_IDLE;
            S_WR: begin
               if (wr_req)        state <= S_WR;
               else if (conflict) state <= S_RDDEF;
               else               state <= S_IDLE;
            end
            S_RDDEF: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.rw_conflict = conflict;
   assign bus.mem_cs      = cs;
   assign bus.mem_we      = we;
   assign bus.mem_addr    = addr;
   assign bus.mem_bwe     = bwe_all;
   assign bus.mem_wdata   = bus.hwdata;
   assign bus.rd_grp      = rd_grp_q;
endmodule

// File: tb/tb_sram_access_sched.sv
// Directed cycle-by-cycle vectors for the SRAM access scheduler, plus a reset-during-deferral sequence.
module tb_sram_access_sched;
   logic hclk = 1'b0;
   logic n_hreset;

   sram_access_sched_if #(.NUM_GROUPS(4), .MEM_AW(10)) bus ();

   sram_access_sched #(.NUM_GROUPS(4), .MEM_AW(10), .GRP_LSB(12)) dut (
      .hclk     (hclk),
      .n_hreset (n_hreset),
      .bus      (bus)
   );

   always #5 hclk = ~hclk;

   typedef struct {
      logic        rst_n;
      logic        va;
      logic        wr;
      logic [2:0]  sz;
      logic [31:0] addr;
      logic [31:0] wd;
      logic        conf;
      logic [3:0]  cs;
      logic [3:0]  we;
      logic [39:0] maddr;
      logic [15:0] bwe;
      logic [1:0]  rdg;
   } vec_t;

   int checks = 0;
   int errors = 0;

   function automatic vec_t v(input logic rst_n, input logic va, input logic wr,
                              input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd,
                              input logic conf, input logic [3:0] cs, input logic [3:0] we,
                              input logic [39:0] maddr, input logic [15:0] bwe, input logic [1:0] rdg);
      vec_t r;
      r.rst_n = rst_n; r.va = va; r.wr = wr; r.sz = sz; r.addr = addr; r.wd = wd;
      r.conf = conf; r.cs = cs; r.we = we; r.maddr = maddr; r.bwe = bwe; r.rdg = rdg;
      return r;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
      end
   endtask

   // Drive one cycle just after the rising edge, check mid-cycle on the falling edge.
   task automatic apply(input vec_t t, input int idx);
      @(posedge hclk);
      #1;
      n_hreset         = t.rst_n;
      bus.valid_access = t.va;
      bus.hwrite       = t.wr;
      bus.hsize        = t.sz;
      bus.haddr        = t.addr;
      bus.hwdata       = t.wd;
      @(negedge hclk);
      chk("rw_conflict", idx, 64'(bus.rw_conflict), 64'(t.conf));
      chk("mem_cs",      idx, 64'(bus.mem_cs),      64'(t.cs));
      chk("mem_we",      idx, 64'(bus.mem_we),      64'(t.we));
      chk("mem_addr",    idx, 64'(bus.mem_addr),    64'(t.maddr));
      chk("mem_bwe",     idx, 64'(bus.mem_bwe),     64'(t.bwe));
      chk("mem_wdata",   idx, 64'(bus.mem_wdata),   64'(t.wd));
      chk("rd_grp",      idx, 64'(bus.rd_grp),      64'(t.rdg));
   endtask

   vec_t tbl[34];

   initial begin
      #20000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      n_hreset         = 1'b0;
      bus.valid_access = 1'b0;
      bus.hwrite       = 1'b0;
      bus.hsize        = 3'b000;
      bus.haddr        = '0;
      bus.hwdata       = '0;

      //        rst va wr sz addr        wdata          conf cs       we       maddr              bwe       rdg
      tbl[0]  = v(0, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[1]  = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[2]  = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[3]  = v(1, 0, 0, 0, 32'h0,    32'hDEADBEEF,  0, 4'b0001, 4'b0001, 40'h41,            16'h000F, 0);
      tbl[4]  = v(1, 1, 1, 0, 32'h2006, 32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[5]  = v(1, 1, 1, 1, 32'h2006, 32'h11223344,  0, 4'b0100, 4'b0100, 40'h100000,        16'h0400, 0);
      tbl[6]  = v(1, 0, 0, 0, 32'h0,    32'h55667788,  0, 4'b0100, 4'b0100, 40'h100000,        16'h0C00, 0);
      tbl[7]  = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[8]  = v(1, 1, 0, 2, 32'h108,  32'hCAFEF00D,  1, 4'b0001, 4'b0001, 40'h41,            16'h000F, 0);
      tbl[9]  = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0001, 4'b0000, 40'h42,            16'h0000, 0);
      tbl[10] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[11] = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[12] = v(1, 1, 0, 2, 32'h1008, 32'h0BADF00D,  0, 4'b0011, 4'b0001, 40'h841,           16'h000F, 0);
      tbl[13] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 1);
      tbl[14] = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 1);
      tbl[15] = v(1, 1, 0, 2, 32'h108,  32'h0,         1, 4'b0001, 4'b0001, 40'h41,            16'h000F, 1);
      tbl[16] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0001, 4'b0000, 40'h42,            16'h0000, 1);
      tbl[17] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[18] = v(1, 1, 1, 2, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[19] = v(1, 1, 1, 2, 32'h1000, 32'h00000001,  0, 4'b0001, 4'b0001, 40'h0,             16'h000F, 0);
      tbl[20] = v(1, 1, 1, 2, 32'h0,    32'h00000002,  0, 4'b0010, 4'b0010, 40'h0,             16'h00F0, 0);
      tbl[21] = v(1, 0, 0, 0, 32'h0,    32'h00000003,  0, 4'b0001, 4'b0001, 40'h0,             16'h000F, 0);
      tbl[22] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[23] = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[24] = v(1, 1, 0, 2, 32'h108,  32'h0,         1, 4'b0001, 4'b0001, 40'h41,            16'h000F, 0);
      tbl[25] = v(1, 1, 1, 2, 32'h2000, 32'h0,         0, 4'b0001, 4'b0000, 40'h42,            16'h0000, 0);
      tbl[26] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[27] = v(1, 1, 0, 0, 32'h3004, 32'h0,         0, 4'b1000, 4'b0000, 40'h0040000000,    16'h0000, 0);
      tbl[28] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 3);
      tbl[29] = v(1, 1, 1, 2, 32'h104,  32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 3);
      tbl[30] = v(0, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[31] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[32] = v(1, 1, 0, 2, 32'h0,    32'h0,         0, 4'b0001, 4'b0000, 40'h0,             16'h0000, 0);
      tbl[33] = v(1, 0, 0, 0, 32'h0,    32'h0,         0, 4'b0000, 4'b0000, 40'h0,             16'h0000, 0);

      for (int i = 0; i < 34; i++) begin
         apply(tbl[i], i);
      end

      // Reset lands in the deferred-read cycle; the read must never reappear.
      apply(v(1, 1, 1, 2, 32'h104,  32'h0, 0, 4'b0000, 4'b0000, 40'h0, 16'h0000, 0), 100);
      apply(v(1, 1, 0, 2, 32'h108,  32'h0, 1, 4'b0001, 4'b0001, 40'h41, 16'h000F, 0), 101);
      apply(v(0, 0, 0, 0, 32'h0,    32'h0, 0, 4'b0000, 4'b0000, 40'h0, 16'h0000, 0), 102);
      apply(v(1, 0, 0, 0, 32'h0,    32'h0, 0, 4'b0000, 4'b0000, 40'h0, 16'h0000, 0), 103);
      apply(v(1, 0, 0, 0, 32'h0,    32'h0, 0, 4'b0000, 4'b0000, 40'h0, 16'h0000, 0), 104);
      apply(v(1, 1, 0, 2, 32'h1000, 32'h0, 0, 4'b0010, 4'b0000, 40'h0, 16'h0000, 0), 105);
      apply(v(1, 0, 0, 0, 32'h0,    32'h0, 0, 4'b0000, 4'b0000, 40'h0, 16'h0000, 1), 106);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
